// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into little-endian 32-bit words and writes them to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte after the last word.
module imem_loader #(
   parameter int MEM_BYTES = 96
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] base_addr,
   input  logic [15:0] word_count,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [63:0] wr_addr,
   output logic [31:0] wr_data,
   input  logic        wr_ack,
   output logic        busy,
   output logic        done,
   output logic        error
);
   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE
   } state_t;
   state_t      state_q;
   logic [1:0]  idx_q;
   logic [15:0] rem_q;
   logic [63:0] addr_q;
   logic [31:0] data_q, data_d;
   logic        ready_q, wr_en_q, busy_q, done_q, error_q;
   logic [64:0] end_d;
   logic        bad_d, take_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q;
`endif
   // carry bit catches a wrap past 2^64 as out of range
   assign end_d  = {1'b0, base_addr} + {47'd0, word_count, 2'b00};
   assign bad_d  = (word_count == 16'd0) || (base_addr[1:0] != 2'b00) || (end_d > 65'(MEM_BYTES));
   assign take_d = byte_valid && ready_q;
   always_comb begin
      data_d = data_q;
      data_d[{idx_q, 3'b000} +: 8] = byte_in;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         wr_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: if (start) begin
               addr_q  <= base_addr;
               rem_q   <= word_count;
               idx_q   <= '0;
               done_q  <= 1'b0;
               error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_q   <= '0;
`endif
               if (bad_d) begin
                  done_q  <= 1'b1;
                  error_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  busy_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= COLLECT;
               end
            end
            COLLECT: if (take_d) begin
               data_q <= data_d;
               idx_q  <= idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_q  <= sum_q + byte_in;
`endif
               if (idx_q == 2'd3) begin
                  ready_q <= 1'b0;
                  wr_en_q <= 1'b1;
                  state_q <= WRITE;
               end
            end
            WRITE: if (wr_ack) begin
               wr_en_q <= 1'b0;
               addr_q  <= addr_q + 64'd4;
               rem_q   <= rem_q - 16'd1;
               if (rem_q == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  ready_q <= 1'b1;
                  state_q <= CHECK;
`else
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
`endif
               end else begin
                  ready_q <= 1'b1;
                  state_q <= COLLECT;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: if (take_d) begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               error_q <= byte_in != sum_q;
               state_q <= DONE;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
   assign byte_ready = ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = addr_q;
   assign wr_data    = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
endmodule
